flash_sample_streamer: RTL and testbench
========================================

// Module: flash_sample_streamer
// PURPOSE
//  Parametrised Avalon-MM flash reader. Fetches DATA_W-bit words and splits each into
//  SPW = DATA_W/SAMPLE_W samples, handed out one per sample_req. Walks START_ADDR..END_ADDR
//  forward or backward with wrap. Sits between the flash controller and the audio/sample consumer.
// PARAMETERS
//  DATA_W     32       flash word width; multiple of 8 and of SAMPLE_W
//  SAMPLE_W   16       sample width; SPW = DATA_W/SAMPLE_W >= 1
//  ADDR_W     23       word address width
//  START_ADDR 0        first word address (inclusive)
//  END_ADDR   'h7FFFF  last word address (inclusive); END_ADDR >= START_ADDR
// PORTS
//  clk                      in   1           clock, all logic on posedge
//  reset                    in   1           synchronous, active-high
//  start                    in   1           begin/resume streaming from IDLE
//  stop                     in   1           finish outstanding read, then go to IDLE
//  restart                  in   1           reload address (START_ADDR fwd / END_ADDR bwd); only acted on in IDLE
//  direction                in   1           0 = forward (low lane first, addr+1); 1 = backward (high lane first, addr-1)
//  sample_req               in   1           consumer requests the next sample
//  sample_out               out  SAMPLE_W    sample data, valid with sample_valid
//  sample_valid             out  1           one-cycle pulse per served request
//  flash_mem_address        out  ADDR_W      word address
//  flash_mem_read           out  1           Avalon read
//  flash_mem_byteenable     out  DATA_W/8    all ones while read=1, else 0
//  flash_mem_waitrequest    in   1           Avalon waitrequest
//  flash_mem_readdata       in   DATA_W      Avalon read data
//  flash_mem_readdatavalid  in   1           Avalon read data valid
//  busy                     out  1           1 in any state except IDLE
//  state_num                out  3           current state encoding, for debug
// BEHAVIOUR
//  - Reset: state IDLE, address START_ADDR, read=0, byteenable=0, sample_valid=0, sample_out=0,
//    busy=0, word buffer and pending flag cleared. Reset takes priority over all inputs in all
//    states; a readdatavalid arriving after reset is ignored.
//  - States (state_num): IDLE=0, REQ=1, WAIT=2, HOLD=3, DRAIN=4.
//  - IDLE: on start=1 and stop=0, go to REQ; read=1 from the next cycle. restart=1 reloads the
//    address in the same cycle.
//  - REQ: read=1 and address stable while waitrequest=1. At the posedge where waitrequest=0,
//    drop read and go to WAIT.
//  - WAIT: on readdatavalid, latch readdata. Lane index = 0 if direction=0, SPW-1 if direction=1.
//    Go to HOLD, or to DRAIN if stop was seen during REQ/WAIT.
//  - HOLD: a sample_req served at edge N gives sample_valid=1 at N+1, with sample_out =
//    word[lane*SAMPLE_W +: SAMPLE_W]; the lane then advances by +/-1.
//    - After the last lane: step the address by +/-1 and go to REQ.
//    - Wrap: forward at END_ADDR goes to START_ADDR; backward at START_ADDR goes to END_ADDR.
//  - A sample_req outside HOLD sets a single pending flag. The flag is served on the first HOLD
//    cycle. Further reqs while pending are dropped.
//  - direction is sampled only when a word is latched; changing it mid-word takes effect at the next word.
//  - stop in HOLD: go to IDLE next cycle, discard the remaining lanes, advance the address one word.
//    stop in REQ/WAIT: complete the accepted read (never abort), then DRAIN -> IDLE.
//    The address is retained for resume.
//  - sample_valid is never asserted in IDLE, REQ, WAIT or DRAIN.
// CONFIGURATION
//  - FLASH_PREFETCH_EN defined: adds a second word buffer. The read of the next word is issued
//    when lane 0 of the current word is served. A req at a word boundary is served from the
//    prefetch buffer with no stall: back-to-back reqs with a 1-cycle flash latency give
//    back-to-back sample_valid. stop discards the prefetch buffer.
//  - Not defined: a single buffer. A req at a word boundary stalls until REQ/WAIT complete.
// TESTING
//  1. Fwd, word@0 = 32'hBBBB_AAAA, waitrequest=0: start, 2 reqs -> sample_out AAAA then BBBB;
//     next read address = 1.
//  2. Bwd, same word: start from END_ADDR with word 32'hBBBB_AAAA -> BBBB then AAAA;
//     next address = END_ADDR-1.
//  3. END_ADDR=3, START_ADDR=0, fwd: consume all lanes at addr 3 -> next read address = 0;
//     bwd at 0 -> next address = 3.
//  4. waitrequest=1 for 5 cycles -> read=1, byteenable=4'hF, address constant for 5 cycles;
//     read=0 the cycle after waitrequest falls.
//  5. stop asserted in WAIT, readdatavalid 3 cycles later -> data absorbed, no sample_valid,
//     IDLE (state_num=0) 2 cycles later. reset asserted in WAIT -> IDLE; late readdatavalid ignored.
//  6. FLASH_PREFETCH_EN, 8 consecutive reqs, 1-cycle flash latency -> 8 consecutive
//     sample_valid pulses with no gap.

Source files
------------

// File: rtl/flash_sample_streamer.sv
// Avalon-MM flash reader that splits each DATA_W word into SAMPLE_W samples served one per request.
// Optional FLASH_PREFETCH_EN adds a second word buffer so word boundaries do not stall the consumer.
module flash_sample_streamer #(
    parameter int unsigned        DATA_W     = 32,
    parameter int unsigned        SAMPLE_W   = 16,
    parameter int unsigned        ADDR_W     = 23,
    parameter logic [ADDR_W-1:0]  START_ADDR = '0,
    parameter logic [ADDR_W-1:0]  END_ADDR   = ADDR_W'('h7FFFF)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  restart,
    input  logic                  direction,
    input  logic                  sample_req,
    output logic [SAMPLE_W-1:0]   sample_out,
    output logic                  sample_valid,
    output logic [ADDR_W-1:0]     flash_mem_address,
    output logic                  flash_mem_read,
    output logic [DATA_W/8-1:0]   flash_mem_byteenable,
    input  logic                  flash_mem_waitrequest,
    input  logic [DATA_W-1:0]     flash_mem_readdata,
    input  logic                  flash_mem_readdatavalid,
    output logic                  busy,
    output logic [2:0]            state_num
);

    localparam int unsigned SPW    = DATA_W / SAMPLE_W;
    localparam int unsigned LANE_W = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam logic [LANE_W-1:0] LANE_HI = LANE_W'(SPW - 1);
`ifdef FLASH_PREFETCH_EN
    localparam bit PF_EN = 1'b1;
`else
    localparam bit PF_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    typedef enum logic [1:0] {PF_NONE, PF_REQ, PF_WAIT, PF_FULL} pf_t;

    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a, input logic bwd);
        if (!bwd) return (a == END_ADDR) ? START_ADDR : a + ADDR_W'(1);
        return (a == START_ADDR) ? END_ADDR : a - ADDR_W'(1);
    endfunction

    function automatic logic [LANE_W-1:0] first_lane(input logic bwd);
        return bwd ? LANE_HI : '0;
    endfunction

    function automatic logic [LANE_W-1:0] last_lane(input logic bwd);
        return bwd ? '0 : LANE_HI;
    endfunction

    state_t              state_q, state_d;
    pf_t                 pf_st_q, pf_st_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                read_q, read_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                sv_q, sv_d;
    logic [SAMPLE_W-1:0] so_q, so_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [DATA_W-1:0]   pf_buf_q, pf_buf_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic                dir_q, dir_d;
    logic                pend_q, pend_d;
    logic                stop_seen_q, stop_seen_d;
    logic                empty_q, empty_d;

    logic [DATA_W-1:0]   cur_word;
    logic [LANE_W-1:0]   cur_lane;
    logic                cur_dir;
    logic                can_serve;
    logic                serve_req;

    always_comb begin
        state_d     = state_q;
        pf_st_d     = pf_st_q;
        addr_d      = addr_q;
        read_d      = read_q;
        sv_d        = 1'b0;
        so_d        = so_q;
        word_d      = word_q;
        pf_buf_d    = pf_buf_q;
        lane_d      = lane_q;
        dir_d       = dir_q;
        pend_d      = pend_q;
        stop_seen_d = stop_seen_q;
        empty_d     = empty_q;
        cur_word    = word_q;
        cur_lane    = lane_q;
        cur_dir     = dir_q;
        can_serve   = !empty_q;
        serve_req   = sample_req || pend_q;

        if (state_q != S_HOLD && sample_req) pend_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                stop_seen_d = 1'b0;
                if (restart) addr_d = direction ? END_ADDR : START_ADDR;
                if (start && !stop) begin
                    state_d = S_REQ;
                    read_d  = 1'b1;
                end
            end
            S_REQ: begin
                if (stop) stop_seen_d = 1'b1;
                if (!flash_mem_waitrequest) begin
                    read_d  = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (stop) stop_seen_d = 1'b1;
                if (flash_mem_readdatavalid) begin
                    word_d  = flash_mem_readdata;
                    dir_d   = direction;
                    lane_d  = first_lane(direction);
                    empty_d = 1'b0;
                    state_d = (stop_seen_q || stop) ? S_DRAIN : S_HOLD;
                end
            end
            S_DRAIN: begin
                stop_seen_d = 1'b0;
                state_d     = S_IDLE;
            end
            S_HOLD: begin
                // Background prefetch progress; an exhausted word may be refilled from it directly.
                if (PF_EN) begin
                    if (pf_st_q == PF_REQ && !flash_mem_waitrequest) begin
                        read_d  = 1'b0;
                        pf_st_d = PF_WAIT;
                    end
                    if (pf_st_q == PF_WAIT && flash_mem_readdatavalid) begin
                        pf_buf_d = flash_mem_readdata;
                        pf_st_d  = PF_FULL;
                    end
                    if (empty_q) begin
                        cur_dir  = direction;
                        cur_lane = first_lane(direction);
                        if (pf_st_q == PF_FULL) begin
                            cur_word  = pf_buf_q;
                            can_serve = 1'b1;
                        end else if (pf_st_q == PF_WAIT && flash_mem_readdatavalid) begin
                            cur_word  = flash_mem_readdata;
                            can_serve = 1'b1;
                        end
                    end
                end

                if (stop) begin
                    // An accepted prefetch read must still complete before going idle.
                    if (PF_EN && pf_st_d == PF_REQ) begin
                        state_d     = S_REQ;
                        stop_seen_d = 1'b1;
                    end else if (PF_EN && pf_st_d == PF_WAIT) begin
                        state_d     = S_WAIT;
                        stop_seen_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        if (!PF_EN || pf_st_q == PF_NONE) addr_d = step_addr(addr_q, dir_q);
                    end
                    pf_st_d = PF_NONE;
                end else if (serve_req && can_serve) begin
                    sv_d    = 1'b1;
                    pend_d  = 1'b0;
                    so_d    = cur_word[SAMPLE_W*int'(cur_lane) +: SAMPLE_W];
                    word_d  = cur_word;
                    dir_d   = cur_dir;
                    empty_d = 1'b0;
                    if (PF_EN && empty_q) pf_st_d = PF_NONE;
                    if (cur_lane == last_lane(cur_dir)) begin
                        if (PF_EN) begin
                            empty_d = 1'b1;
                        end else begin
                            addr_d  = step_addr(addr_q, cur_dir);
                            state_d = S_REQ;
                            read_d  = 1'b1;
                        end
                    end else begin
                        lane_d = cur_dir ? cur_lane - LANE_W'(1) : cur_lane + LANE_W'(1);
                    end
                    if (PF_EN && cur_lane == first_lane(cur_dir)) begin
                        read_d  = 1'b1;
                        addr_d  = step_addr(addr_q, cur_dir);
                        pf_st_d = PF_REQ;
                    end
                end else if (sample_req) begin
                    pend_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        be_d   = read_d ? '1 : '0;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pf_st_q     <= PF_NONE;
            addr_q      <= START_ADDR;
            read_q      <= 1'b0;
            be_q        <= '0;
            sv_q        <= 1'b0;
            so_q        <= '0;
            busy_q      <= 1'b0;
            word_q      <= '0;
            pf_buf_q    <= '0;
            lane_q      <= '0;
            dir_q       <= 1'b0;
            pend_q      <= 1'b0;
            stop_seen_q <= 1'b0;
            empty_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            pf_st_q     <= pf_st_d;
            addr_q      <= addr_d;
            read_q      <= read_d;
            be_q        <= be_d;
            sv_q        <= sv_d;
            so_q        <= so_d;
            busy_q      <= busy_d;
            word_q      <= word_d;
            pf_buf_q    <= pf_buf_d;
            lane_q      <= lane_d;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            stop_seen_q <= stop_seen_d;
            empty_q     <= empty_d;
        end
    end

    assign sample_out           = so_q;
    assign sample_valid         = sv_q;
    assign flash_mem_address    = addr_q;
    assign flash_mem_read       = read_q;
    assign flash_mem_byteenable = be_q;
    assign busy                 = busy_q;
    assign state_num            = state_q;

endmodule

// File: tb/tb_flash_sample_streamer.sv
// Directed bench for flash_sample_streamer with a small Avalon flash model (4 words, END_ADDR=3).
// The prefetch scenario is compiled only when FLASH_PREFETCH_EN is defined.
module tb_flash_sample_streamer;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned ADDR_W   = 23;

    logic                clk = 1'b0;
    logic                reset, start, stop, restart, direction, sample_req;
    logic [SAMPLE_W-1:0] sample_out;
    logic                sample_valid;
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic [3:0]          byteenable;
    logic                wr;
    logic [DATA_W-1:0]   readdata = '0;
    logic                rdv = 1'b0;
    logic                busy;
    logic [2:0]          state_num;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0]       mem [4];
    logic              auto_resp = 1'b1;
    logic              man_rdv = 1'b0;
    logic [31:0]       man_data = '0;
    logic              acc_n = 1'b0;
    logic [ADDR_W-1:0] acc_addr_n = '0;
    bit                ok;

    flash_sample_streamer #(
        .DATA_W(DATA_W), .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W),
        .START_ADDR(23'd0), .END_ADDR(23'd3)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .restart(restart),
        .direction(direction), .sample_req(sample_req), .sample_out(sample_out),
        .sample_valid(sample_valid), .flash_mem_address(address), .flash_mem_read(read),
        .flash_mem_byteenable(byteenable), .flash_mem_waitrequest(wr),
        .flash_mem_readdata(readdata), .flash_mem_readdatavalid(rdv),
        .busy(busy), .state_num(state_num)
    );

    always #5 clk = ~clk;

    // Flash slave: a read accepted in cycle c returns data during cycle c+1.
    always @(negedge clk) begin
        acc_n      = read && !wr;
        acc_addr_n = address;
    end

    always @(posedge clk) begin
        #2;
        if (auto_resp) begin
            rdv      = acc_n;
            readdata = acc_n ? mem[acc_addr_n[1:0]] : '0;
        end else begin
            rdv      = man_rdv;
            readdata = man_data;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (state_num == s) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic start_stream(input logic dir, input logic rld);
        direction = dir;
        restart   = rld;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        restart   = 1'b0;
    endtask

    task automatic go_idle(output bit found);
        stop = 1'b1;
        wait_state(3'd0, found);
        stop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++; if (state_num !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state_num); end
        n_cmp++; if (read !== 1'b0) begin n_err++; $display("FAIL reset_read got %b want 0", read); end
        n_cmp++; if (byteenable !== 4'h0) begin n_err++; $display("FAIL reset_be got %h want 0", byteenable); end
        n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", sample_valid); end
        n_cmp++; if (sample_out !== 16'h0) begin n_err++; $display("FAIL reset_out got %h want 0", sample_out); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (address !== 23'd0) begin n_err++; $display("FAIL reset_addr got %h want 0", address); end
        reset = 1'b0;
    endtask

    task automatic test_forward();
        mem[0] = 32'hBBBB_AAAA;
        mem[1] = 32'h1111_0001;
        start_stream(1'b0, 1'b1);
        n_cmp++; if (state_num !== 3'd1) begin n_err++; $display("FAIL fwd_req_state got %0d want 1", state_num); end
        n_cmp++; if (read !== 1'b1 || byteenable !== 4'hF) begin n_err++; $display("FAIL fwd_read got %b/%h want 1/f", read, byteenable); end
        n_cmp++; if (address !== 23'd0) begin n_err++; $display("FAIL fwd_addr0 got %h want 0", address); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL fwd_busy got %b want 1", busy); end
        wait_state(3'd3, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL fwd_hold_timeout got state %0d want 3", state_num); end
        sample_req = 1'b1;
        tick();
        n_cmp++; if (sample_valid !== 1'b1 || sample_out !== 16'hAAAA) begin n_err++; $display("FAIL fwd_lane0 got %b/%h want 1/aaaa", sample_valid, sample_out); end
        tick();
        n_cmp++; if (sample_valid !== 1'b1 || sample_out !== 16'hBBBB) begin n_err++; $display("FAIL fwd_lane1 got %b/%h want 1/bbbb", sample_valid, sample_out); end
        n_cmp++; if (address !== 23'd1 || read !== 1'b1) begin n_err++; $display("FAIL fwd_next_addr got %h/%b want 1/1", address, read); end
        sample_req = 1'b0;
        tick();
        n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL fwd_valid_pulse got %b want 0", sample_valid); end
        go_idle(ok);
        n_cmp++; if (!ok || address !== 23'd1) begin n_err++; $display("FAIL fwd_resume_addr got %h want 1", address); end
    endtask

    task automatic test_backward();
        mem[2] = 32'h2222_1111;
        mem[3] = 32'hBBBB_AAAA;
        start_stream(1'b1, 1'b1);
        n_cmp++; if (address !== 23'd3) begin n_err++; $display("FAIL bwd_start_addr got %h want 3", address); end
        wait_state(3'd3, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL bwd_hold_timeout got state %0d want 3", state_num); end
        sample_req = 1'b1;
        tick();
        n_cmp++; if (sample_out !== 16'hBBBB || sample_valid !== 1'b1) begin n_err++; $display("FAIL bwd_lane1 got %b/%h want 1/bbbb", sample_valid, sample_out); end
        tick();
        n_cmp++; if (sample_out !== 16'hAAAA || sample_valid !== 1'b1) begin n_err++; $display("FAIL bwd_lane0 got %b/%h want 1/aaaa", sample_valid, sample_out); end
        n_cmp++; if (address !== 23'd2) begin n_err++; $display("FAIL bwd_next_addr got %h want 2", address); end
        sample_req = 1'b0;
        go_idle(ok);
        n_cmp++; if (!ok || address !== 23'd2) begin n_err++; $display("FAIL bwd_resume_addr got %h want 2", address); end
    endtask

    task automatic test_wrap();
        mem[0] = 32'hBBBB_AAAA;
        start_stream(1'b0, 1'b0);
        wait_state(3'd3, ok);
        sample_req = 1'b1;
        tick();
        n_cmp++; if (sample_out !== 16'h1111) begin n_err++; $display("FAIL wrap_w2_lo got %h want 1111", sample_out); end
        tick();
        n_cmp++; if (sample_out !== 16'h2222 || address !== 23'd3) begin n_err++; $display("FAIL wrap_w2_hi got %h/%h want 2222/3", sample_out, address); end
        sample_req = 1'b0;
        wait_state(3'd3, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_hold_timeout got state %0d want 3", state_num); end
        sample_req = 1'b1;
        tick();
        tick();
        n_cmp++; if (sample_out !== 16'hBBBB || address !== 23'd0) begin n_err++; $display("FAIL wrap_fwd_end got %h/%h want bbbb/0", sample_out, address); end
        sample_req = 1'b0;
        go_idle(ok);
        start_stream(1'b1, 1'b0);
        wait_state(3'd3, ok);
        sample_req = 1'b1;
        tick();
        n_cmp++; if (sample_out !== 16'hBBBB) begin n_err++; $display("FAIL wrap_bwd_hi got %h want bbbb", sample_out); end
        tick();
        n_cmp++; if (sample_out !== 16'hAAAA || address !== 23'd3) begin n_err++; $display("FAIL wrap_bwd_start got %h/%h want aaaa/3", sample_out, address); end
        sample_req = 1'b0;
        go_idle(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_idle_timeout got state %0d want 0", state_num); end
    endtask

    task automatic test_waitrequest();
        wr = 1'b1;
        start_stream(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (read !== 1'b1 || byteenable !== 4'hF || address !== 23'd0) begin
                n_err++;
                $display("FAIL wr_hold cycle %0d got %b/%h/%h want 1/f/0", i, read, byteenable, address);
            end
            tick();
        end
        wr = 1'b0;
        n_cmp++; if (read !== 1'b1) begin n_err++; $display("FAIL wr_fall_read got %b want 1", read); end
        tick();
        n_cmp++; if (read !== 1'b0 || byteenable !== 4'h0 || state_num !== 3'd2) begin n_err++; $display("FAIL wr_accept got %b/%h/%0d want 0/0/2", read, byteenable, state_num); end
        wait_state(3'd3, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL wr_hold_timeout got state %0d want 3", state_num); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++; if (state_num !== 3'd0 || address !== 23'd1 || busy !== 1'b0 || sample_valid !== 1'b0) begin
            n_err++; $display("FAIL stop_hold got %0d/%h/%b/%b want 0/1/0/0", state_num, address, busy, sample_valid);
        end
    endtask

    task automatic test_pending();
        mem[0] = 32'h5678_1234;
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        tick();
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL pend_idle_valid got %b want 0", sample_valid); end
        start_stream(1'b0, 1'b1);
        wait_state(3'd3, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL pend_hold_timeout got state %0d want 3", state_num); end
        tick();
        n_cmp++; if (sample_valid !== 1'b1 || sample_out !== 16'h1234) begin n_err++; $display("FAIL pend_served got %b/%h want 1/1234", sample_valid, sample_out); end
        tick();
        n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL pend_dropped got %b want 0", sample_valid); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_stop_wait();
        auto_resp = 1'b0;
        man_rdv   = 1'b0;
        start_stream(1'b0, 1'b1);
        tick();
        n_cmp++; if (state_num !== 3'd2) begin n_err++; $display("FAIL sw_wait got %0d want 2", state_num); end
        stop = 1'b1;
        sample_req = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        tick();
        n_cmp++; if (state_num !== 3'd2 || sample_valid !== 1'b0) begin n_err++; $display("FAIL sw_still_wait got %0d/%b want 2/0", state_num, sample_valid); end
        man_rdv  = 1'b1;
        man_data = 32'hCAFE_F00D;
        tick();
        man_rdv  = 1'b0;
        n_cmp++; if (state_num !== 3'd4 || sample_valid !== 1'b0) begin n_err++; $display("FAIL sw_drain got %0d/%b want 4/0", state_num, sample_valid); end
        tick();
        n_cmp++; if (state_num !== 3'd0 || sample_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL sw_idle got %0d/%b/%b want 0/0/0", state_num, sample_valid, busy); end
        sample_req = 1'b0;
        start_stream(1'b0, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (state_num !== 3'd0 || read !== 1'b0) begin n_err++; $display("FAIL rst_wait got %0d/%b want 0/0", state_num, read); end
        man_rdv = 1'b1;
        tick();
        man_rdv = 1'b0;
        n_cmp++; if (state_num !== 3'd0 || sample_valid !== 1'b0) begin n_err++; $display("FAIL rst_late_rdv got %0d/%b want 0/0", state_num, sample_valid); end
        tick();
        n_cmp++; if (state_num !== 3'd0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_stays_idle got %0d/%b want 0/0", state_num, busy); end
        auto_resp = 1'b1;
    endtask

`ifdef FLASH_PREFETCH_EN
    task automatic test_prefetch();
        logic [31:0] w;
        logic [15:0] exp_s;
        mem[0] = 32'h0B0B_0A0A;
        mem[1] = 32'h1B1B_1A1A;
        mem[2] = 32'h2B2B_2A2A;
        mem[3] = 32'h3B3B_3A3A;
        start_stream(1'b0, 1'b1);
        wait_state(3'd3, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL pf_hold_timeout got state %0d want 3", state_num); end
        sample_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            w     = mem[i/2];
            exp_s = (i % 2 == 1) ? w[31:16] : w[15:0];
            n_cmp++;
            if (sample_valid !== 1'b1 || sample_out !== exp_s) begin
                n_err++;
                $display("FAIL pf_b2b req %0d got %b/%h want 1/%h", i, sample_valid, sample_out, exp_s);
            end
        end
        sample_req = 1'b0;
        go_idle(ok);
    endtask
`endif

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        restart    = 1'b0;
        direction  = 1'b0;
        sample_req = 1'b0;
        wr         = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        #1;
        test_reset();
        test_forward();
        test_backward();
        test_wrap();
        test_waitrequest();
        test_pending();
        test_stop_wait();
`ifdef FLASH_PREFETCH_EN
        test_prefetch();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
